// File: rtl/router_rd_arb.sv
// rtl/router_rd_arb.sv - round-robin packet read arbiter from three FIFOs onto one stream
// Define ROUTER_RD_ARB_STATS_EN to add per-channel packet counters and an abort counter.
module router_rd_arb #(
    parameter int TIMEOUT = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  fifo_empty,
    input  logic [7:0]  fifo_dout_0,
    input  logic [7:0]  fifo_dout_1,
    input  logic [7:0]  fifo_dout_2,
    input  logic [2:0]  fifo_hdr,
    output logic [2:0]  read_enb,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_sop,
    output logic        m_eop,
    output logic [1:0]  m_chan,
    output logic [2:0]  soft_reset
`ifdef ROUTER_RD_ARB_STATS_EN
    ,
    output logic [15:0] pkt_cnt_0,
    output logic [15:0] pkt_cnt_1,
    output logic [15:0] pkt_cnt_2,
    output logic [15:0] abort_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, XFER, ABORT} state_t;

    state_t     state_q;
    logic [1:0] grant_q;
    logic [1:0] rr_q;
    logic [6:0] rem_q;
    logic [5:0] stall_q;

    logic [2:0] elig;
    logic [2:0] junk;
    logic [2:0] discard;
    logic [7:0] dout_sel;
    logic [1:0] pick;
    logic       pick_vld;
    logic [1:0] next_rr;
    logic       beat;

    assign elig    = ~fifo_empty & fifo_hdr;
    assign junk    = ~fifo_empty & ~fifo_hdr;
    assign next_rr = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
    assign beat    = m_valid && m_ready;
    assign m_chan  = grant_q;

    always_comb begin
        discard = 3'b000;
        if (junk[0])      discard = 3'b001;
        else if (junk[1]) discard = 3'b010;
        else if (junk[2]) discard = 3'b100;
    end

    always_comb begin
        case (grant_q)
            2'd1:    dout_sel = fifo_dout_1;
            2'd2:    dout_sel = fifo_dout_2;
            default: dout_sel = fifo_dout_0;
        endcase
    end

    // Scan from the farthest candidate back to rr_q so the nearest eligible channel wins.
    always_comb begin
        logic [2:0] idx;
        pick     = 2'd0;
        pick_vld = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            idx = {1'b0, rr_q} + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (elig[idx[1:0]]) begin
                pick     = idx[1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Outputs are forced quiet while reset is high so nothing pops or pulses during reset.
    always_comb begin
        m_valid    = 1'b0;
        m_data     = 8'h00;
        m_sop      = 1'b0;
        m_eop      = 1'b0;
        read_enb   = 3'b000;
        soft_reset = 3'b000;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (elig == 3'b000) read_enb = discard;
                end
                XFER: begin
                    m_valid = !fifo_empty[grant_q];
                    if (m_valid) begin
                        m_data   = dout_sel;
                        m_sop    = (rem_q == 7'd0);
                        m_eop    = (rem_q == 7'd1);
                        read_enb = 3'(m_ready) << grant_q;
                    end
                end
                ABORT: soft_reset = 3'b001 << grant_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            rr_q    <= 2'd0;
            rem_q   <= 7'd0;
            stall_q <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick;
                        rem_q   <= 7'd0;
                        stall_q <= 6'd0;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        stall_q <= 6'd0;
                        if (m_sop) rem_q <= {1'b0, dout_sel[7:2]} + 7'd1;
                        else       rem_q <= rem_q - 7'd1;
                        if (m_eop) begin
                            state_q <= IDLE;
                            rr_q    <= next_rr;
                        end
                    end else if (m_valid) begin
                        if (stall_q == 6'(TIMEOUT - 1)) state_q <= ABORT;
                        else                            stall_q <= stall_q + 6'd1;
                    end
                end
                ABORT: begin
                    state_q <= IDLE;
                    rr_q    <= next_rr;
                    rem_q   <= 7'd0;
                    stall_q <= 6'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ROUTER_RD_ARB_STATS_EN
    logic [15:0] pkt0_q, pkt1_q, pkt2_q, abort_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt0_q  <= 16'd0;
            pkt1_q  <= 16'd0;
            pkt2_q  <= 16'd0;
            abort_q <= 16'd0;
        end else begin
            if (beat && m_eop) begin
                case (grant_q)
                    2'd0:    pkt0_q <= pkt0_q + 16'd1;
                    2'd1:    pkt1_q <= pkt1_q + 16'd1;
                    default: pkt2_q <= pkt2_q + 16'd1;
                endcase
            end
            if (state_q == ABORT) abort_q <= abort_q + 16'd1;
        end
    end

    assign pkt_cnt_0 = pkt0_q;
    assign pkt_cnt_1 = pkt1_q;
    assign pkt_cnt_2 = pkt2_q;
    assign abort_cnt = abort_q;
`endif

endmodule

// File: tb/tb_router_rd_arb.sv
// tb/tb_router_rd_arb.sv - scoreboard bench for router_rd_arb with a packet-level reference model
module tb_router_rd_arb;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] fifo_empty;
    logic [7:0] fifo_dout_0, fifo_dout_1, fifo_dout_2;
    logic [2:0] fifo_hdr;
    logic [2:0] read_enb;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_valid, m_sop, m_eop;
    logic [1:0] m_chan;
    logic [2:0] soft_reset;
`ifdef ROUTER_RD_ARB_STATS_EN
    logic [15:0] pkt_cnt_0, pkt_cnt_1, pkt_cnt_2, abort_cnt;
`endif

    router_rd_arb dut (
        .clock(clock), .reset(reset), .fifo_empty(fifo_empty),
        .fifo_dout_0(fifo_dout_0), .fifo_dout_1(fifo_dout_1), .fifo_dout_2(fifo_dout_2),
        .fifo_hdr(fifo_hdr), .read_enb(read_enb), .m_ready(m_ready),
        .m_data(m_data), .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop),
        .m_chan(m_chan), .soft_reset(soft_reset)
`ifdef ROUTER_RD_ARB_STATS_EN
        , .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1), .pkt_cnt_2(pkt_cnt_2), .abort_cnt(abort_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    logic [8:0] fq [3][$];
    beat_t      sb [$];
    logic [2:0] exp_sr [$];
    int         pops [3];
    int         exp_pkt [3];
    int         exp_ab;
    int         rr_m;
    int         ready_mode;
    int         checks = 0;
    int         passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic add_pkt(input int ch, input logic [7:0] hdr);
        fq[ch].push_back({1'b1, hdr});
        for (int i = 0; i <= int'(hdr[7:2]); i++) fq[ch].push_back({1'b0, 8'($urandom)});
    endtask

    // Packet-level reference: grant whole packets round-robin, drop stray words only when no header waits.
    task automatic model_run();
        logic [8:0] m [3][$];
        logic [8:0] w;
        int g, len;
        for (int i = 0; i < 3; i++) m[i] = fq[i];
        while (m[0].size() + m[1].size() + m[2].size() != 0) begin
            g = -1;
            for (int k = 2; k >= 0; k--) begin
                int c = (rr_m + k) % 3;
                if (m[c].size() != 0) begin
                    w = m[c][0];
                    if (w[8]) g = c;
                end
            end
            if (g >= 0) begin
                w = m[g][0];
                len = int'(w[7:2]) + 1;
                for (int b = 0; b <= len; b++) begin
                    w = m[g].pop_front();
                    sb.push_back('{ch: 2'(g), d: w[7:0], sop: (b == 0), eop: (b == len)});
                end
                rr_m = (g + 1) % 3;
            end else begin
                if (m[0].size() != 0)      w = m[0].pop_front();
                else if (m[1].size() != 0) w = m[1].pop_front();
                else                       w = m[2].pop_front();
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || fq[0].size() + fq[1].size() + fq[2].size() != 0) && n < 3000) begin
            cyc();
            n++;
        end
        chk(name, 32'(n < 3000), 32'd1);
        repeat (3) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        rr_m = 0;
        exp_ab = 0;
        for (int i = 0; i < 3; i++) exp_pkt[i] = 0;
    endtask

`ifdef ROUTER_RD_ARB_STATS_EN
    task automatic chk_stats(input string tag);
        chk({tag, "_pkt0"}, 32'(pkt_cnt_0), 32'(exp_pkt[0]));
        chk({tag, "_pkt1"}, 32'(pkt_cnt_1), 32'(exp_pkt[1]));
        chk({tag, "_pkt2"}, 32'(pkt_cnt_2), 32'(exp_pkt[2]));
        chk({tag, "_abort"}, 32'(abort_cnt), 32'(exp_ab));
    endtask
`endif

    // FIFO heads and m_ready are driven on the falling edge.
    initial begin
        logic [8:0] head [3];
        int nrdy = 0;
        fifo_empty = 3'b111; fifo_hdr = 3'b000; m_ready = 1'b0;
        fifo_dout_0 = 8'h00; fifo_dout_1 = 8'h00; fifo_dout_2 = 8'h00;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                fifo_empty[i] = (fq[i].size() == 0);
                head[i] = (fq[i].size() != 0) ? fq[i][0] : 9'h000;
            end
            fifo_hdr    = {head[2][8], head[1][8], head[0][8]};
            fifo_dout_0 = head[0][7:0];
            fifo_dout_1 = head[1][7:0];
            fifo_dout_2 = head[2][7:0];
            if (ready_mode == 0)      m_ready = 1'b0;
            else if (ready_mode == 1) m_ready = 1'b1;
            else begin
                m_ready = ($urandom_range(0, 3) != 0) || (nrdy >= 6);
                nrdy = m_ready ? 0 : nrdy + 1;
            end
        end
    end

    // FIFO side: apply pops and soft resets seen in this cycle.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            for (int i = 0; i < 3; i++) begin
                if (soft_reset[i]) fq[i].delete();
                else if (read_enb[i] && fq[i].size() != 0) begin
                    void'(fq[i].pop_front());
                    pops[i]++;
                end
            end
        end
    end

    // Monitor: every transferred beat and every soft_reset pulse must match the expected queues.
    initial begin
        beat_t e;
        forever begin
            @(negedge clock);
            #3;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) chk("unexpected_beat", {m_chan, m_data}, 32'h0);
                else begin
                    e = sb.pop_front();
                    chk("beat", {m_chan, m_data, m_sop, m_eop}, {e.ch, e.d, e.sop, e.eop});
                    if (e.eop) exp_pkt[e.ch]++;
                end
            end
            if (soft_reset != 3'b000) begin
                if (exp_sr.size() == 0) chk("unexpected_soft_reset", soft_reset, 32'h0);
                else chk("soft_reset", soft_reset, exp_sr.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

    initial begin
        int n, run, p, nv;
        logic [7:0] par;
        ready_mode = 1;
        rr_m = 0;
        exp_ab = 0;
        for (int i = 0; i < 3; i++) begin pops[i] = 0; exp_pkt[i] = 0; end
        reset = 1'b1;
        fq[0].push_back(9'h0AA);
        repeat (2) cyc();
        #3;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_sop", m_sop, 0);
        chk("rst_m_eop", m_eop, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_read_enb", read_enb, 0);
        chk("rst_soft_reset", soft_reset, 0);
        chk("rst_m_chan", m_chan, 0);
`ifdef ROUTER_RD_ARB_STATS_EN
        chk_stats("rst");
`endif
        cyc();
        reset = 1'b0;
        p = pops[0];
        model_run();
        wait_drain("drain_junk_after_reset");
        chk("junk_popped", pops[0] - p, 1);

        // 5-beat packet on channel 1 with m_ready held high
        p = pops[1];
        add_pkt(1, 8'h0D);
        model_run();
        run = 0;
        n = 0;
        while (n < 50) begin
            cyc(); #3; n++;
            if (m_valid && m_ready) run++;
            else if (run > 0) break;
        end
        chk("pkt5_consecutive_beats", run, 5);
        wait_drain("drain_pkt5");
        chk("pkt5_read_enb_count", pops[1] - p, 5);

        // Round-robin order 0,1,2,0 after reset
        do_reset();
        add_pkt(0, 8'h04); add_pkt(0, 8'h04); add_pkt(1, 8'h04); add_pkt(2, 8'h04);
        model_run();
        wait_drain("drain_rr");

        // Randomised rounds with stray words and random backpressure
        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            for (int ch = 0; ch < 3; ch++) begin
                int np = $urandom_range(0, 3);
                for (int k = 0; k < np; k++) begin
                    if ($urandom_range(0, 3) == 0) fq[ch].push_back({1'b0, 8'($urandom)});
                    add_pkt(ch, {6'($urandom_range(0, 6)), 2'($urandom)});
                end
            end
            model_run();
            wait_drain("drain_random");
        end

        // Stall timeout on channel 2
        do_reset();
        ready_mode = 0;
        add_pkt(2, 8'h08);
        n = 0;
        while (n < 20) begin
            cyc(); #3; n++;
            if (m_valid) break;
        end
        chk("stall_grant_ch2", m_chan, 2);
        p = pops[2];
        add_pkt(0, 8'h04);
        add_pkt(1, 8'h00);
        exp_sr.push_back(3'b100);
        exp_ab++;
        n = 0;
        while (exp_sr.size() != 0 && n < 60) begin
            cyc(); #3; n++;
        end
        chk("abort_seen", exp_sr.size(), 0);
        chk("abort_after_timeout_cycles", n, 30);
        chk("abort_no_read_ch2", pops[2] - p, 0);
        rr_m = 0;
        model_run();
        ready_mode = 1;
        wait_drain("drain_after_abort");
`ifdef ROUTER_RD_ARB_STATS_EN
        chk_stats("after_abort");
`endif

        // Zero-length packet whose parity arrives late
        par = 8'($urandom);
        p = pops[0];
        fq[0].push_back(9'h100);
        sb.push_back('{ch: 2'd0, d: 8'h00, sop: 1'b1, eop: 1'b0});
        sb.push_back('{ch: 2'd0, d: par, sop: 1'b0, eop: 1'b1});
        rr_m = 1;
        n = 0;
        while (pops[0] == p && n < 20) begin cyc(); n++; end
        chk("zero_len_header_taken", pops[0] - p, 1);
        ready_mode = 0;
        nv = 0;
        repeat (40) begin
            cyc(); #3;
            if (m_valid) nv++;
        end
        chk("empty_midpkt_no_valid", nv, 0);
        fq[0].push_back({1'b0, par});
        ready_mode = 1;
        wait_drain("drain_zero_len");

        // Stray word with nothing eligible
        p = pops[0];
        fq[0].push_back(9'h05C);
        model_run();
        wait_drain("drain_stray");
        chk("stray_popped", pops[0] - p, 1);

        // Reset in the middle of a packet
        p = pops[1];
        add_pkt(1, 8'h15);
        model_run();
        n = 0;
        while (pops[1] - p < 2 && n < 30) begin cyc(); n++; end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) fq[i].delete();
        sb.delete();
        #3;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_read_enb", read_enb, 0);
        chk("midrst_sop_eop", {m_sop, m_eop}, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_soft_reset", soft_reset, 0);
        cyc(); #3;
        chk("midrst_m_chan", m_chan, 0);
        cyc();
        reset = 1'b0;
        rr_m = 0;
        exp_ab = 0;
        for (int i = 0; i < 3; i++) exp_pkt[i] = 0;
        add_pkt(1, 8'h04);
        add_pkt(0, 8'h04);
        model_run();
        ready_mode = 2;
        wait_drain("drain_after_midrst");
`ifdef ROUTER_RD_ARB_STATS_EN
        chk_stats("final");
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
